fp_special_pack: RTL

- Encode-side counterpart of the special-value detectors (inf/NaN/zero checks).
- Takes a classified result from an arithmetic datapath and packs it into an IEEE-754-style word {sign, expo, mant}.
- Substitutes canonical encodings for NaN, infinity and zero, and applies rounding-mode-dependent overflow saturation.
- Two-stage valid/ready pipeline with full backpressure; sits at the tail of the FP units, before result writeback.

---
 rtl/fp_special_pack_if.sv | 39 +++
 rtl/fp_special_pack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_special_pack_if.sv
// Valid/ready bus for the FP special-value packer: classified result in, packed word out.
interface fp_special_pack_if #(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
);
    localparam int unsigned FP_W = 1 + EXPO_W + MANT_W;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXPO_W-1:0] in_expo;
    logic [MANT_W-1:0] in_mant;
    logic              in_is_nan;
    logic              in_snan;
    logic              in_is_inf;
    logic              in_is_zero;
    logic              in_ovf;
    logic              in_inexact;
    logic [2:0]        in_rm;
    logic              out_valid;
    logic              out_ready;
    logic [FP_W-1:0]   out_fp;
    logic              out_res_inf;
    logic [2:0]        out_flags;

    // Producer of classified results / consumer of packed words
    modport master (
        output in_valid, in_sign, in_expo, in_mant, in_is_nan, in_snan, in_is_inf,
               in_is_zero, in_ovf, in_inexact, in_rm, out_ready,
        input  in_ready, out_valid, out_fp, out_res_inf, out_flags
    );

    // The packer itself
    modport slave (
        input  in_valid, in_sign, in_expo, in_mant, in_is_nan, in_snan, in_is_inf,
               in_is_zero, in_ovf, in_inexact, in_rm, out_ready,
        output in_ready, out_valid, out_fp, out_res_inf, out_flags
    );
endinterface

// File: rtl/fp_special_pack.sv
// Packs a classified FP result into {sign, expo, mant}, substituting canonical
// NaN/inf/zero encodings and rounding-mode-dependent overflow saturation.
// Two register stages with full backpressure.
module fp_special_pack #(
    parameter int unsigned SIGN_W = 1,
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
) (
    input logic               clk,
    input logic               rst,
    fp_special_pack_if.slave  bus
);
    localparam int unsigned FP_W = SIGN_W + EXPO_W + MANT_W;

    localparam logic [EXPO_W-1:0] MaxE     = '1;
    localparam logic [EXPO_W-1:0] MaxFinE  = {{(EXPO_W-1){1'b1}}, 1'b0};
    localparam logic [MANT_W-1:0] QnanMant = {1'b1, {(MANT_W-1){1'b0}}};

    // One-hot result class chosen in stage 1
    typedef enum logic [4:0] {
        CaseFin  = 5'b00001,
        CaseOvf  = 5'b00010,
        CaseZero = 5'b00100,
        CaseInf  = 5'b01000,
        CaseNan  = 5'b10000
    } case_e;

    // Stage 1 state
    logic              r_s1_valid;
    logic              r_s1_sign;
    case_e             r_s1_sel;
    logic [2:0]        r_s1_rm;
    logic              r_s1_inexact;
    logic              r_s1_snan;
    logic [EXPO_W-1:0] r_s1_expo;
    logic [MANT_W-1:0] r_s1_mant;

    // Stage 2 (output) state
    logic              r_s2_valid;
    logic [FP_W-1:0]   r_s2_fp;
    logic              r_s2_res_inf;
    logic [2:0]        r_s2_flags;

    logic              w_s2_free;
    logic              w_s1_load;
    case_e             w_sel;
    logic              w_sign;
    logic [EXPO_W-1:0] w_expo;
    logic [MANT_W-1:0] w_mant;
    logic              w_ovf_inf;
    logic              w_nv;
    logic              w_of;
    logic              w_nx;
    logic [FP_W-1:0]   w_fp;
    logic              w_res_inf;

    assign w_s2_free    = !r_s2_valid || bus.out_ready;
    assign bus.in_ready = !r_s1_valid || w_s2_free;
    assign w_s1_load    = bus.in_valid && bus.in_ready;

    // Classify by priority nan > inf > zero > ovf > finite; a finite result with
    // an all-ones exponent cannot be represented and is treated as overflow.
    always_comb begin
        w_sel = CaseFin;
        if (bus.in_is_nan) begin
            w_sel = CaseNan;
        end else if (bus.in_is_inf) begin
            w_sel = CaseInf;
        end else if (bus.in_is_zero) begin
            w_sel = CaseZero;
        end else if (bus.in_ovf || (&bus.in_expo)) begin
            w_sel = CaseOvf;
        end
    end

    // Stage 1 valid: set on accept, cleared when the beat moves to stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 1 payload capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sign    <= 1'b0;
            r_s1_sel     <= CaseFin;
            r_s1_rm      <= 3'd0;
            r_s1_inexact <= 1'b0;
            r_s1_snan    <= 1'b0;
            r_s1_expo    <= '0;
            r_s1_mant    <= '0;
        end else if (w_s1_load) begin
            r_s1_sign    <= bus.in_sign;
            r_s1_sel     <= w_sel;
            r_s1_rm      <= bus.in_rm;
            r_s1_inexact <= bus.in_inexact;
            r_s1_snan    <= bus.in_snan;
            r_s1_expo    <= bus.in_expo;
            r_s1_mant    <= bus.in_mant;
        end
    end

    // Overflow direction: 1 = saturate to infinity, 0 = to max finite.
    // Reserved rounding modes fall into the RNE default.
    always_comb begin
        w_ovf_inf = 1'b1;
        unique case (r_s1_rm)
            3'd1:    w_ovf_inf = 1'b0;        // RTZ
            3'd2:    w_ovf_inf = r_s1_sign;   // RDN: only negative goes to -inf
            3'd3:    w_ovf_inf = !r_s1_sign;  // RUP: only positive goes to +inf
            default: w_ovf_inf = 1'b1;        // RNE, RMM, reserved
        endcase
    end

    // Stage 2 encoding and exception flags
    always_comb begin
        w_sign = r_s1_sign;
        w_expo = r_s1_expo;
        w_mant = r_s1_mant;
        w_nv   = 1'b0;
        w_of   = 1'b0;
        w_nx   = 1'b0;
        unique case (r_s1_sel)
            CaseNan: begin
                w_sign = 1'b0;
                w_expo = MaxE;
                w_mant = QnanMant;
                w_nv   = r_s1_snan;
            end
            CaseInf: begin
                w_expo = MaxE;
                w_mant = '0;
            end
            CaseZero: begin
                w_expo = '0;
                w_mant = '0;
                w_nx   = r_s1_inexact;
            end
            CaseOvf: begin
                w_of = 1'b1;
                w_nx = 1'b1;
                if (w_ovf_inf) begin
                    w_expo = MaxE;
                    w_mant = '0;
                end else begin
                    w_expo = MaxFinE;
                    w_mant = '1;
                end
            end
            default: begin
                w_nx = r_s1_inexact;
            end
        endcase
    end

    assign w_fp      = {w_sign, w_expo, w_mant};
    assign w_res_inf = (&w_expo) && (w_mant == '0);

    // Stage 2 register: advances only when the output slot is free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_fp      <= '0;
            r_s2_res_inf <= 1'b0;
            r_s2_flags   <= 3'b000;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_fp      <= w_fp;
                r_s2_res_inf <= w_res_inf;
                r_s2_flags   <= {w_nv, w_of, w_nx};
            end
        end
    end

    assign bus.out_valid   = r_s2_valid;
    assign bus.out_fp      = r_s2_fp;
    assign bus.out_res_inf = r_s2_res_inf;
    assign bus.out_flags   = r_s2_flags;
endmodule
